// File: rtl/i2c_cfg_seq.sv
// rtl/i2c_cfg_seq.sv - table-driven WM8978 I2C configuration sequencer with retry, restart and volume update
module i2c_cfg_seq #(
   parameter int REG_NUM        = 17,
   parameter int ADDR_W         = 7,
   parameter int DATA_W         = 9,
   parameter int WL             = 32,
   parameter int PWRUP_DLY      = 252,
   parameter int RST_DLY        = 252,
   parameter int RETRY_DLY      = 64,
   parameter int MAX_RETRY      = 3,
   parameter int PHONE_VOL_INIT = 20,
   parameter int SPEAK_VOL_INIT = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i2c_done,
   input  logic                     i2c_nack,
   output logic                     i2c_exec,
   output logic [ADDR_W+DATA_W-1:0] i2c_data,
   input  logic                     cfg_restart,
   input  logic                     vol_upd,
   input  logic [5:0]               phone_vol,
   input  logic [5:0]               speak_vol,
   output logic                     busy,
   output logic                     cfg_done,
   output logic                     cfg_err,
   output logic [4:0]               err_idx
);

   localparam int DW    = ADDR_W + DATA_W;
   localparam int CNT_W = 16;
   localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

   localparam logic [1:0] WL_CODE = (WL == 16) ? 2'd0 :
                                    (WL == 20) ? 2'd1 :
                                    (WL == 24) ? 2'd2 :
                                    (WL == 32) ? 2'd3 : 2'd0;

   // Last index of a full pass and of a volume-only pass (never beyond the table)
   localparam logic [4:0] FULL_LAST = 5'(REG_NUM - 1);
   localparam logic [4:0] VOL_LAST  = (REG_NUM > 16) ? 5'd15 : 5'(REG_NUM - 1);
   localparam bit         VOL_OK    = (REG_NUM > 12);

   // Delay counters count from 0 up to DLY-1 inclusive
   localparam logic [CNT_W-1:0] PWRUP_END = CNT_W'((PWRUP_DLY > 0) ? PWRUP_DLY - 1 : 0);
   localparam logic [CNT_W-1:0] RST_END   = CNT_W'((RST_DLY   > 0) ? RST_DLY   - 1 : 0);
   localparam logic [CNT_W-1:0] RETRY_END = CNT_W'((RETRY_DLY > 0) ? RETRY_DLY - 1 : 0);
   localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_PWRUP,
      S_ISSUE,
      S_WAIT,
      S_GAP,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] gap_end_q, gap_end_d;
   logic [RTY_W-1:0] rty_q, rty_d;
   logic [4:0]       idx_q, idx_d;
   logic             vol_pass_q, vol_pass_d;
   logic [5:0]       phone_q, phone_d;
   logic [5:0]       speak_q, speak_d;
   logic             pend_q, pend_d;
   logic [5:0]       pend_phone_q, pend_phone_d;
   logic [5:0]       pend_speak_q, pend_speak_d;
   logic             exec_q, exec_d;
   logic [DW-1:0]    data_q, data_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [4:0]       err_idx_q, err_idx_d;
   logic             busy_w;

   // Register table: {address, data} for entry i using the given volumes
   function automatic logic [DW-1:0] entry(input logic [4:0] i,
                                           input logic [5:0] ph,
                                           input logic [5:0] sp);
      logic [6:0] a;
      logic [8:0] d;
      a = 7'd0;
      d = 9'd0;
      case (i)
         5'd0:    begin a = 7'd0;  d = 9'h001; end
         5'd1:    begin a = 7'd1;  d = 9'h007; end
         5'd2:    begin a = 7'd1;  d = 9'h02F; end
         5'd3:    begin a = 7'd2;  d = 9'h180; end
         5'd4:    begin a = 7'd4;  d = {2'b00, WL_CODE, 5'b10000}; end
         5'd5:    begin a = 7'd6;  d = 9'h001; end
         5'd6:    begin a = 7'd7;  d = 9'h001; end
         5'd7:    begin a = 7'd10; d = 9'h008; end
         5'd8:    begin a = 7'd43; d = 9'h010; end
         5'd9:    begin a = 7'd49; d = 9'h006; end
         5'd10:   begin a = 7'd50; d = 9'h001; end
         5'd11:   begin a = 7'd51; d = 9'h001; end
         5'd12:   begin a = 7'd52; d = {3'b010, ph}; end
         5'd13:   begin a = 7'd53; d = {3'b110, ph}; end
         5'd14:   begin a = 7'd54; d = {3'b010, sp}; end
         5'd15:   begin a = 7'd55; d = {3'b110, sp}; end
         5'd16:   begin a = 7'd3;  d = 9'h06F; end
         default: begin a = 7'd0;  d = 9'h000; end
      endcase
      return {ADDR_W'(a), DATA_W'(d)};
   endfunction

   assign busy_w = (state_q != S_DONE) && (state_q != S_ERR);

   // Next-state, counters, volume bookkeeping and registered I2C outputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gap_end_d    = gap_end_q;
      rty_d        = rty_q;
      idx_d        = idx_q;
      vol_pass_d   = vol_pass_q;
      phone_d      = phone_q;
      speak_d      = speak_q;
      pend_d       = pend_q;
      pend_phone_d = pend_phone_q;
      pend_speak_d = pend_speak_q;
      done_d       = done_q;
      err_d        = err_q;
      err_idx_d    = err_idx_q;

      // A volume request while busy is parked; the newest values win
      if (busy_w && vol_upd) begin
         pend_d       = 1'b1;
         pend_phone_d = phone_vol;
         pend_speak_d = speak_vol;
      end

      case (state_q)
         S_PWRUP: begin
            if (cnt_q >= PWRUP_END) begin
               state_d = S_ISSUE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i2c_done) begin
               if (!i2c_nack) begin
                  rty_d = '0;
                  idx_d = idx_q + 5'd1;
                  if (idx_q == (vol_pass_q ? VOL_LAST : FULL_LAST)) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else if (!vol_pass_q && (idx_q <= 5'd1)) begin
                     // Soft reset and VMID enable need settling time
                     state_d   = S_GAP;
                     cnt_d     = '0;
                     gap_end_d = RST_END;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end else if (rty_q < RTY_MAX) begin
                  rty_d     = rty_q + RTY_W'(1);
                  state_d   = S_GAP;
                  cnt_d     = '0;
                  gap_end_d = RETRY_END;
               end else begin
                  err_d     = 1'b1;
                  err_idx_d = idx_q;
                  state_d   = S_ERR;
               end
            end
         end
         S_GAP: begin
            if (cnt_q >= gap_end_q) begin
               state_d = S_ISSUE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            // Fresh request beats a parked one; either way the volumes are taken now
            if (vol_upd) begin
               phone_d = phone_vol;
               speak_d = speak_vol;
            end else if (pend_q) begin
               phone_d = pend_phone_q;
               speak_d = pend_speak_q;
            end
            pend_d = 1'b0;
            if (cfg_restart) begin
               done_d     = 1'b0;
               idx_d      = '0;
               rty_d      = '0;
               cnt_d      = '0;
               vol_pass_d = 1'b0;
               state_d    = S_PWRUP;
            end else if ((vol_upd || pend_q) && VOL_OK) begin
               idx_d      = 5'd12;
               rty_d      = '0;
               vol_pass_d = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ERR: begin
            pend_d = 1'b0;
            if (cfg_restart) begin
               err_d      = 1'b0;
               err_idx_d  = '0;
               done_d     = 1'b0;
               idx_d      = '0;
               rty_d      = '0;
               cnt_d      = '0;
               vol_pass_d = 1'b0;
               state_d    = S_PWRUP;
            end
         end
         default: begin
            state_d = S_PWRUP;
         end
      endcase

      // Exec and data are registered so they change together on entry to ISSUE
      exec_d = (state_d == S_ISSUE);
      data_d = exec_d ? entry(idx_d, phone_d, speak_d) : data_q;
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_PWRUP;
         cnt_q        <= '0;
         gap_end_q    <= '0;
         rty_q        <= '0;
         idx_q        <= '0;
         vol_pass_q   <= 1'b0;
         phone_q      <= 6'(PHONE_VOL_INIT);
         speak_q      <= 6'(SPEAK_VOL_INIT);
         pend_q       <= 1'b0;
         pend_phone_q <= '0;
         pend_speak_q <= '0;
         exec_q       <= 1'b0;
         data_q       <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_idx_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gap_end_q    <= gap_end_d;
         rty_q        <= rty_d;
         idx_q        <= idx_d;
         vol_pass_q   <= vol_pass_d;
         phone_q      <= phone_d;
         speak_q      <= speak_d;
         pend_q       <= pend_d;
         pend_phone_q <= pend_phone_d;
         pend_speak_q <= pend_speak_d;
         exec_q       <= exec_d;
         data_q       <= data_d;
         done_q       <= done_d;
         err_q        <= err_d;
         err_idx_q    <= err_idx_d;
      end
   end

   assign i2c_exec = exec_q;
   assign i2c_data = data_q;
   assign busy     = busy_w;
   assign cfg_done = done_q;
   assign cfg_err  = err_q;
   assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// tb/tb_i2c_cfg_seq.sv - directed bench for i2c_cfg_seq with an I2C slave model
module tb_i2c_cfg_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i2c_done, i2c_nack, cfg_restart, vol_upd;
   logic [5:0]  phone_vol, speak_vol;
   logic        i2c_exec, busy, cfg_done, cfg_err;
   logic [15:0] i2c_data;
   logic [4:0]  err_idx;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [15:0] log_data[$];
   int          log_edge[$];
   int          cyc, cd, done_rise;
   logic        done_prev, nack_now;
   logic [15:0] nack_data;
   int          nack_left = 0;
   bit          track_done = 0;
   bit          done_low_seen = 0;

   always #5 clk = ~clk;

   i2c_cfg_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i2c_done   (i2c_done),
      .i2c_nack   (i2c_nack),
      .i2c_exec   (i2c_exec),
      .i2c_data   (i2c_data),
      .cfg_restart(cfg_restart),
      .vol_upd    (vol_upd),
      .phone_vol  (phone_vol),
      .speak_vol  (speak_vol),
      .busy       (busy),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .err_idx    (err_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Hand-encoded {addr,data} words of the WM8978 table (WL = 32)
   function automatic logic [15:0] exp_entry(input int i, input int ph, input int sp);
      case (i)
         0:  return 16'h0001;
         1:  return 16'h0207;
         2:  return 16'h022F;
         3:  return 16'h0580;
         4:  return 16'h0870;
         5:  return 16'h0C01;
         6:  return 16'h0E01;
         7:  return 16'h1408;
         8:  return 16'h5610;
         9:  return 16'h6206;
         10: return 16'h6401;
         11: return 16'h6601;
         12: return 16'h6880 | 16'(ph);
         13: return 16'h6B80 | 16'(ph);
         14: return 16'h6C80 | 16'(sp);
         15: return 16'h6F80 | 16'(sp);
         16: return 16'h066F;
         default: return 16'hFFFF;
      endcase
   endfunction

   // Slave model: done 10 edges after exec, optional NACK on a chosen word; also edge bookkeeping
   initial begin
      i2c_done = 1'b0; i2c_nack = 1'b0; nack_now = 1'b0;
      cyc = 0; cd = 0; done_rise = -1; done_prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         i2c_done = 1'b0;
         i2c_nack = 1'b0;
         if (!rst_n) begin
            cyc = 0; cd = 0; done_prev = 1'b0;
         end else begin
            cyc++;
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  i2c_done = 1'b1;
                  i2c_nack = nack_now;
               end
            end
            if (i2c_exec) begin
               log_data.push_back(i2c_data);
               log_edge.push_back(cyc + 1);
               nack_now = 1'b0;
               if (nack_left > 0 && i2c_data == nack_data) begin
                  nack_now = 1'b1;
                  nack_left--;
               end
               cd = 9;
            end
            if (cfg_done && !done_prev) done_rise = cyc;
            if (!cfg_done && track_done) done_low_seen = 1;
            done_prev = cfg_done;
         end
      end
   end

   task automatic do_reset(input string tag);
      rst_n = 1'b0; cfg_restart = 1'b0; vol_upd = 1'b0;
      phone_vol = 6'd0; speak_vol = 6'd0;
      repeat (3) @(posedge clk);
      #2;
      check({tag, "_rst_exec"}, i2c_exec, 0);
      check({tag, "_rst_data"}, i2c_data, 0);
      check({tag, "_rst_done"}, cfg_done, 0);
      check({tag, "_rst_err"}, cfg_err, 0);
      check({tag, "_rst_erridx"}, err_idx, 0);
      check({tag, "_rst_busy"}, busy, 1);
      log_data.delete();
      log_edge.delete();
      done_rise = -1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (busy && n < max);
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic wait_log(input string tag, input int cnt, input int max);
      int n = 0;
      while (log_data.size() < cnt && n < max) begin
         @(posedge clk); #2;
         n++;
      end
      check({tag, "_logreach"}, (log_data.size() >= cnt), 1);
   endtask

   task automatic pulse_restart();
      @(posedge clk); #2;
      cfg_restart = 1'b1;
      @(posedge clk); #2;
      cfg_restart = 1'b0;
   endtask

   task automatic pulse_vol(input logic [5:0] ph, input logic [5:0] sp);
      @(posedge clk); #2;
      vol_upd = 1'b1; phone_vol = ph; speak_vol = sp;
      @(posedge clk); #2;
      vol_upd = 1'b0;
   endtask

   initial begin
      cfg_restart = 1'b0; vol_upd = 1'b0; phone_vol = 6'd0; speak_vol = 6'd0;

      // Plain power-up sequence
      do_reset("s1");
      wait_idle("s1", 3000);
      check("s1_count", log_data.size(), 17);
      for (int i = 0; i < 17 && i < log_data.size(); i++)
         check($sformatf("s1_data%0d", i), log_data[i], exp_entry(i, 20, 40));
      if (log_data.size() >= 17) begin
         check("s1_first_edge", log_edge[0], 253);
         check("s1_gap0", log_edge[1] - log_edge[0], 262);
         check("s1_gap1", log_edge[2] - log_edge[1], 262);
         check("s1_gap2", log_edge[3] - log_edge[2], 10);
         check("s1_done_rise", done_rise, log_edge[16] + 9);
      end
      check("s1_done", cfg_done, 1);
      check("s1_err", cfg_err, 0);

      // Entry 8 NACKed twice then accepted
      nack_data = 16'h5610; nack_left = 2;
      do_reset("s2");
      wait_idle("s2", 3000);
      check("s2_count", log_data.size(), 19);
      for (int j = 0; j < 19 && j < log_data.size(); j++)
         check($sformatf("s2_data%0d", j), log_data[j],
               exp_entry((j <= 8) ? j : (j <= 10) ? 8 : j - 2, 20, 40));
      if (log_data.size() >= 11) begin
         check("s2_retry1", log_edge[9] - log_edge[8], 74);
         check("s2_retry2", log_edge[10] - log_edge[9], 74);
      end
      check("s2_err", cfg_err, 0);
      check("s2_done", cfg_done, 1);

      // Entry 5 NACKed beyond the retry budget, then restart
      nack_data = 16'h0C01; nack_left = 4;
      do_reset("s3");
      wait_idle("s3", 3000);
      check("s3_count", log_data.size(), 9);
      if (log_data.size() >= 9) check("s3_last", log_data[8], 16'h0C01);
      check("s3_err", cfg_err, 1);
      check("s3_erridx", err_idx, 5);
      check("s3_done", cfg_done, 0);
      repeat (100) @(posedge clk);
      #2;
      check("s3_quiet", log_data.size(), 9);
      log_data.delete(); log_edge.delete();
      pulse_restart();
      check("s3_err_clr", cfg_err, 0);
      check("s3_erridx_clr", err_idx, 0);
      check("s3_busy", busy, 1);
      wait_idle("s3r", 3000);
      check("s3r_count", log_data.size(), 17);
      check("s3r_done", cfg_done, 1);

      // Volume-only pass from DONE
      log_data.delete(); log_edge.delete();
      track_done = 1; done_low_seen = 0;
      pulse_vol(6'd63, 6'd0);
      wait_idle("s4", 500);
      track_done = 0;
      check("s4_count", log_data.size(), 4);
      if (log_data.size() >= 4) begin
         check("s4_w0", log_data[0], 16'h68BF);
         check("s4_w1", log_data[1], 16'h6BBF);
         check("s4_w2", log_data[2], 16'h6C80);
         check("s4_w3", log_data[3], 16'h6F80);
      end
      check("s4_done_low", done_low_seen, 0);
      check("s4_done", cfg_done, 1);

      // Volume request during the initial sequence is deferred
      nack_left = 0;
      do_reset("s5");
      wait_log("s5", 4, 2000);
      pulse_vol(6'd10, 6'd40);
      wait_idle("s5a", 3000);
      @(posedge clk); #2;
      wait_idle("s5b", 500);
      check("s5_count", log_data.size(), 21);
      if (log_data.size() >= 21) begin
         check("s5_init_phone", log_data[12], 16'h6894);
         check("s5_vol0", log_data[17], 16'h688A);
         check("s5_vol1", log_data[18], 16'h6B8A);
         check("s5_vol2", log_data[19], 16'h6CA8);
      end

      // Reset in the middle of entry 9
      do_reset("s6pre");
      wait_log("s6", 10, 2000);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_async_data", i2c_data, 0);
      check("s6_async_busy", busy, 1);
      do_reset("s6");
      wait_log("s6b", 1, 400);
      if (log_data.size() >= 1) begin
         check("s6_first_edge", log_edge[0], 253);
         check("s6_first_data", log_data[0], 16'h0001);
      end
      wait_idle("s6", 3000);
      check("s6_count", log_data.size(), 17);
      check("s6_done", cfg_done, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
